// File: rtl/decode_stage_if.sv
// Handshake and decoded-field bundle between fetch, decode and execute.
// Slave modport is the decode stage; master is its surroundings.
interface decode_stage_if #(
    parameter int XLEN = 32
);
    logic            flush;
    logic            in_valid;
    logic            in_ready;
    logic [31:0]     in_inst;
    logic [XLEN-1:0] in_pc;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] out_pc;
    logic            rd_e;
    logic            rs1_e;
    logic            rs2_e;
    logic [4:0]      rd;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic            imm_e;
    logic [XLEN-1:0] imm;
    logic            pc_e;
    logic [16:0]     full_inst;
    logic            illegal;

    modport slave (
        input  flush, in_valid, in_inst, in_pc, out_ready,
        output in_ready, out_valid, out_pc,
        output rd_e, rs1_e, rs2_e, rd, rs1, rs2,
        output imm_e, imm, pc_e, full_inst, illegal
    );

    modport master (
        output flush, in_valid, in_inst, in_pc, out_ready,
        input  in_ready, out_valid, out_pc,
        input  rd_e, rs1_e, rs2_e, rd, rs1, rs2,
        input  imm_e, imm, pc_e, full_inst, illegal
    );
endinterface

// File: rtl/decode_stage.sv
// RV decode stage: combinational decode into a main + skid buffer.
// Optional DECODE_STAGE_ILLEGAL_EN builds illegal-instruction detection.
module decode_stage #(
    parameter int XLEN = 32
) (
    input  logic           clk,
    input  logic           rst,
    decode_stage_if.slave  bus
);
    typedef enum logic [1:0] {EMPTY, FULL, SKID} state_t;

    typedef struct packed {
        logic            rd_e;
        logic            rs1_e;
        logic            rs2_e;
        logic [4:0]      rd;
        logic [4:0]      rs1;
        logic [4:0]      rs2;
        logic            imm_e;
        logic [XLEN-1:0] imm;
        logic            pc_e;
        logic [16:0]     full_inst;
        logic            illegal;
        logic [XLEN-1:0] pc;
    } entry_t;

    state_t state_q, state_d;
    entry_t main_q, skid_q, dec;
    logic   in_ready_q, out_valid_q;
    logic   push, pop;

    logic [31:0] ins;
    logic [6:0]  op;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;

    assign ins = bus.in_inst;
    assign op  = ins[6:0];
    assign f3  = ins[14:12];
    assign f7  = ins[31:25];

    assign imm_i = {{20{ins[31]}}, ins[31:20]};
    assign imm_s = {{20{ins[31]}}, ins[31:25], ins[11:7]};
    assign imm_b = {{20{ins[31]}}, ins[7], ins[30:25], ins[11:8], 1'b0};
    assign imm_u = {ins[31:12], 12'b0};
    assign imm_j = {{12{ins[31]}}, ins[19:12], ins[20], ins[30:21], 1'b0};

    // Decode the incoming instruction into an entry
    always_comb begin
        dec    = '0;
        dec.pc = bus.in_pc;
        unique case (op)
            7'h33: begin
                dec.rd_e  = 1'b1;
                dec.rs1_e = 1'b1;
                dec.rs2_e = 1'b1;
                dec.full_inst = {f7, f3, op};
`ifdef DECODE_STAGE_ILLEGAL_EN
                dec.illegal = (f7 != 7'h00) && (f7 != 7'h20);
`endif
            end
            7'h13, 7'h03, 7'h67, 7'h73, 7'h0f: begin
                dec.rd_e  = 1'b1;
                dec.rs1_e = 1'b1;
                dec.imm_e = 1'b1;
                dec.imm   = XLEN'($signed(imm_i));
                dec.full_inst = {7'b0, f3, op};
            end
            7'h23, 7'h63: begin
                dec.rs1_e = 1'b1;
                dec.rs2_e = 1'b1;
                dec.imm_e = 1'b1;
                dec.pc_e  = (op == 7'h63);
                dec.imm   = (op == 7'h63) ? XLEN'($signed(imm_b))
                                          : XLEN'($signed(imm_s));
                dec.full_inst = {7'b0, f3, op};
            end
            7'h37, 7'h17, 7'h6f: begin
                dec.rd_e  = 1'b1;
                dec.imm_e = 1'b1;
                dec.pc_e  = 1'b1;
                dec.imm   = (op == 7'h6f) ? XLEN'($signed(imm_j))
                                          : XLEN'($signed(imm_u));
                dec.full_inst = {10'b0, op};
            end
            default: begin
`ifdef DECODE_STAGE_ILLEGAL_EN
                dec.illegal = 1'b1;
`endif
            end
        endcase
`ifdef DECODE_STAGE_ILLEGAL_EN
        if (ins[1:0] != 2'b11) dec.illegal = 1'b1;
`endif
        dec.rd  = dec.rd_e  ? ins[11:7]  : 5'd0;
        dec.rs1 = dec.rs1_e ? ins[19:15] : 5'd0;
        dec.rs2 = dec.rs2_e ? ins[24:20] : 5'd0;
    end

    assign push = bus.in_valid && in_ready_q;
    assign pop  = out_valid_q && bus.out_ready;

    // Next buffer state; flush wins over push and pop
    always_comb begin
        state_d = state_q;
        if (bus.flush) begin
            state_d = EMPTY;
        end else begin
            unique case (state_q)
                EMPTY:   if (push) state_d = FULL;
                FULL:    if (push && !pop) state_d = SKID;
                         else if (!push && pop) state_d = EMPTY;
                SKID:    if (pop) state_d = FULL;
                default: state_d = EMPTY;
            endcase
        end
    end

    // State, registered handshake flags and buffer entries
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= EMPTY;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            main_q      <= '0;
            skid_q      <= '0;
        end else begin
            state_q     <= state_d;
            in_ready_q  <= (state_d != SKID);
            out_valid_q <= (state_d != EMPTY);
            if (!bus.flush) begin
                unique case (state_q)
                    EMPTY: if (push) main_q <= dec;
                    FULL: begin
                        if (push && pop) main_q <= dec;
                        else if (push)   skid_q <= dec;
                    end
                    SKID:  if (pop) main_q <= skid_q;
                    default: ;
                endcase
            end
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_pc    = main_q.pc;
    assign bus.rd_e      = main_q.rd_e;
    assign bus.rs1_e     = main_q.rs1_e;
    assign bus.rs2_e     = main_q.rs2_e;
    assign bus.rd        = main_q.rd;
    assign bus.rs1       = main_q.rs1;
    assign bus.rs2       = main_q.rs2;
    assign bus.imm_e     = main_q.imm_e;
    assign bus.imm       = main_q.imm;
    assign bus.pc_e      = main_q.pc_e;
    assign bus.full_inst = main_q.full_inst;
    assign bus.illegal   = main_q.illegal;
endmodule

// File: tb/tb_decode_stage.sv
// Directed + random bench for decode_stage with an ordered scoreboard.
// Runs a 32-bit instance and a 64-bit instance side by side.
module tb_decode_stage;
    logic clk = 1'b0;
    logic rst;
    int   n_cmp = 0;
    int   n_err = 0;

`ifdef DECODE_STAGE_ILLEGAL_EN
    localparam bit ILL_EN = 1'b1;
`else
    localparam bit ILL_EN = 1'b0;
`endif

    decode_stage_if #(.XLEN(32)) b ();
    decode_stage_if #(.XLEN(64)) w ();

    decode_stage #(.XLEN(32)) u32 (.clk(clk), .rst(rst), .bus(b.slave));
    decode_stage #(.XLEN(64)) u64 (.clk(clk), .rst(rst), .bus(w.slave));

    always #5 clk = ~clk;

    logic [101:0] q[$];
    logic [31:0]  pc = 32'h1000;

    function automatic logic [101:0] model(input logic [31:0] i,
                                           input logic [31:0] p);
        logic [6:0]  o;
        logic        r, s1, s2, ie, pe, ill;
        logic [31:0] im;
        logic [16:0] fi;
        o = i[6:0];
        r = 0; s1 = 0; s2 = 0; ie = 0; pe = 0; ill = 0;
        im = 0; fi = 0;
        if (o == 7'b0110011) begin
            r = 1; s1 = 1; s2 = 1;
            fi = {i[31:25], i[14:12], o};
            ill = ILL_EN && !(i[31:25] == 0 || i[31:25] == 7'b0100000);
        end else if (o inside {7'b0010011, 7'b0000011, 7'b1100111,
                               7'b1110011, 7'b0001111}) begin
            r = 1; s1 = 1; ie = 1;
            im = {{20{i[31]}}, i[31:20]};
            fi = {7'b0, i[14:12], o};
        end else if (o == 7'b0100011) begin
            s1 = 1; s2 = 1; ie = 1;
            im = {{20{i[31]}}, i[31:25], i[11:7]};
            fi = {7'b0, i[14:12], o};
        end else if (o == 7'b1100011) begin
            s1 = 1; s2 = 1; ie = 1; pe = 1;
            im = {{19{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0};
            fi = {7'b0, i[14:12], o};
        end else if (o == 7'b0110111 || o == 7'b0010111) begin
            r = 1; ie = 1; pe = 1;
            im = {i[31:12], 12'h000};
            fi = {10'b0, o};
        end else if (o == 7'b1101111) begin
            r = 1; ie = 1; pe = 1;
            im = {{11{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0};
            fi = {10'b0, o};
        end else begin
            ill = ILL_EN;
        end
        if (i[1:0] != 2'b11) ill = ILL_EN;
        return {r, s1, s2,
                r ? i[11:7] : 5'd0,
                s1 ? i[19:15] : 5'd0,
                s2 ? i[24:20] : 5'd0,
                ie, im, pe, fi, ill, p};
    endfunction

    function automatic logic [101:0] obs();
        return {b.rd_e, b.rs1_e, b.rs2_e, b.rd, b.rs1, b.rs2,
                b.imm_e, b.imm, b.pc_e, b.full_inst, b.illegal, b.out_pc};
    endfunction

    task automatic chk(input string tag, input logic [127:0] o,
                       input logic [127:0] e);
        n_cmp++;
        assert (o === e) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, o, e);
        end
    endtask

    // Sample handshakes mid-cycle, then advance past the next edge
    task automatic step();
        logic [101:0] e;
        @(negedge clk);
        if (rst || b.flush) begin
            q.delete();
        end else begin
            if (b.out_valid && b.out_ready) begin
                if (q.size() == 0) begin
                    chk("sb_unexpected", obs(), 102'h0);
                    chk("sb_unexpected_valid", 1'b1, 1'b0);
                end else begin
                    e = q.pop_front();
                    chk("sb_order", obs(), e);
                end
            end
            if (b.in_valid && b.in_ready)
                q.push_back(model(b.in_inst, b.in_pc));
        end
        @(posedge clk);
        #1;
    endtask

    task automatic put(input logic [31:0] inst);
        b.in_valid = 1'b1;
        b.in_inst  = inst;
        b.in_pc    = pc;
        pc         = pc + 4;
    endtask

    logic [6:0]  ops[12];
    logic [31:0] pa, pb, pcc, ri;

    initial begin
        ops = '{7'h33, 7'h13, 7'h03, 7'h67, 7'h73, 7'h0f,
                7'h23, 7'h63, 7'h37, 7'h17, 7'h6f, 7'h7f};
        rst = 1'b1;
        b.flush = 0; b.in_valid = 0; b.in_inst = 0; b.in_pc = 0;
        b.out_ready = 1;
        w.flush = 0; w.in_valid = 0; w.in_inst = 0; w.in_pc = 0;
        w.out_ready = 1;
        #1;
        chk("rst_out_valid", b.out_valid, 1'b0);
        chk("rst_in_ready", b.in_ready, 1'b1);
        chk("rst_fields", obs(), 102'h0);
        step();
        step();
        rst = 1'b0;
        step();

        // addi x1,x0,-1
        put(32'hFFF00093);
        step();
        b.in_valid = 0;
        chk("addi_valid", b.out_valid, 1'b1);
        chk("addi_rd", b.rd, 5'd1);
        chk("addi_rs1", b.rs1, 5'd0);
        chk("addi_rs1_e", b.rs1_e, 1'b1);
        chk("addi_imm", b.imm, 32'hFFFFFFFF);
        chk("addi_imm_e", b.imm_e, 1'b1);
        chk("addi_full", b.full_inst, 17'h00013);
        step();

        // add then sub back-to-back
        put(32'h002081B3);
        step();
        chk("add_full", b.full_inst, 17'h00033);
        chk("add_regs", {b.rd, b.rs1, b.rs2}, {5'd3, 5'd1, 5'd2});
        put(32'h402081B3);
        step();
        b.in_valid = 0;
        chk("sub_full", b.full_inst, 17'h08033);
        chk("sub_regs", {b.rd, b.rs1, b.rs2}, {5'd3, 5'd1, 5'd2});
        step();
        chk("drain_empty", b.out_valid, 1'b0);

        // back-pressure: A, B fill buffers, C blocked
        b.out_ready = 0;
        pa = pc; put(32'h00112423);
        step();
        pb = pc; put(32'hFE208EE3);
        step();
        chk("skid_in_ready", b.in_ready, 1'b0);
        pcc = pc; put(32'h123450B7);
        step();
        chk("blocked_in_ready", b.in_ready, 1'b0);
        chk("stable_pc_a", b.out_pc, pa);
        b.out_ready = 1;
        step();
        chk("after_pop_in_ready", b.in_ready, 1'b1);
        chk("order_pc_b", b.out_pc, pb);
        step();
        b.in_valid = 0;
        chk("order_pc_c", b.out_pc, pcc);
        step();
        chk("bp_empty", b.out_valid, 1'b0);
        chk("bp_queue", q.size(), 0);

        // flush in SKID with a concurrent push
        b.out_ready = 0;
        put(32'h00500113);
        step();
        put(32'h00600193);
        step();
        put(32'h00700213);
        b.flush = 1;
        step();
        b.flush = 0;
        b.in_valid = 0;
        chk("flush_valid", b.out_valid, 1'b0);
        chk("flush_ready", b.in_ready, 1'b1);
        b.out_ready = 1;
        step();
        step();
        chk("flush_no_emit", b.out_valid, 1'b0);

        // all-ones word
        put(32'hFFFFFFFF);
        step();
        b.in_valid = 0;
        chk("ones_illegal", b.illegal, ILL_EN);
        chk("ones_fields", {b.rd_e, b.rs1_e, b.rs2_e, b.imm_e, b.pc_e,
                            b.rd, b.rs1, b.rs2, b.imm, b.full_inst}, 0);
        step();

        // random traffic against the scoreboard
        for (int k = 0; k < 300; k++) begin
            ri = $urandom();
            ri[6:0] = ops[$urandom_range(0, 11)];
            if ($urandom_range(0, 3) == 0) ri[1:0] = 2'($urandom_range(0, 2));
            b.in_valid  = ($urandom_range(0, 2) != 0);
            b.in_inst   = ri;
            b.in_pc     = pc;
            pc          = pc + 4;
            b.out_ready = ($urandom_range(0, 2) != 0);
            b.flush     = ($urandom_range(0, 49) == 0);
            step();
        end
        b.in_valid = 0;
        b.flush = 0;
        b.out_ready = 1;
        step();
        step();
        step();
        chk("rand_drained", q.size(), 0);
        chk("rand_empty", b.out_valid, 1'b0);

        // reset while both entries are held
        b.out_ready = 0;
        put(32'h00A00293);
        step();
        put(32'h00B00313);
        step();
        b.in_valid = 0;
        rst = 1'b1;
        #1;
        chk("async_rst_valid", b.out_valid, 1'b0);
        chk("async_rst_ready", b.in_ready, 1'b1);
        step();
        rst = 1'b0;
        b.out_ready = 1;
        pa = pc; put(32'h00C00393);
        step();
        b.in_valid = 0;
        chk("post_rst_valid", b.out_valid, 1'b1);
        chk("post_rst_pc", b.out_pc, pa);
        step();

        // 64-bit datapath: jal x1,8 and addi -1
        w.in_valid = 1;
        w.in_inst  = 32'h008000EF;
        w.in_pc    = 64'h8000_0000_0000_0010;
        step();
        chk("jal64_imm", w.imm, 64'h8);
        chk("jal64_en", {w.pc_e, w.rd_e, w.rs1_e, w.imm_e}, 4'b1101);
        chk("jal64_full", w.full_inst, 17'h0006F);
        chk("jal64_pc", w.out_pc, 64'h8000_0000_0000_0010);
        w.in_inst = 32'hFFF00093;
        step();
        w.in_valid = 0;
        chk("addi64_imm", w.imm, 64'hFFFF_FFFF_FFFF_FFFF);
        step();
        chk("w_empty", w.out_valid, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/decode_stage.md
DECODE_STAGE -- requirements
Module: decode_stage

Interface
REQ-001 SHALL provide parameter XLEN, default 32, datapath width of pc and imm (legal values 32, 64).
REQ-002 SHALL provide port clk  input  1  single clock; all state updates on its rising edge.
REQ-003 SHALL provide port rst  input  1  reset, asynchronous, active-high.
REQ-004 SHALL provide port flush  input  1  discards all buffered instructions.
REQ-005 SHALL provide ports in_valid (input, 1), in_ready (output, 1), in_inst (input, 32) and in_pc (input, XLEN) as the upstream instruction handshake.
REQ-006 SHALL provide ports out_valid (output, 1), out_ready (input, 1) and out_pc (output, XLEN) as the downstream handshake.
REQ-007 SHALL provide decoded outputs rd_e/rs1_e/rs2_e (1 each), rd/rs1/rs2 (5 each), imm_e (1, select imm for ALU B), imm (XLEN), pc_e (1, select pc for ALU A), full_inst (17, {func7,func3,opcode}) and illegal (1).

Function
REQ-008 SHALL decode R-type (0110011) as: rd_e/rs1_e/rs2_e=1; imm_e=0; pc_e=0; full_inst={inst[31:25],inst[14:12],inst[6:0]}.
REQ-009 SHALL decode I-type (0010011, 0000011, 1100111, 1110011, 0001111) as: rd_e/rs1_e=1; rs2_e=0; imm_e=1; pc_e=0; imm=sext(inst[31:20]); full_inst={7'b0,func3,opcode}.
REQ-010 SHALL decode S (0100011) with imm=sext({inst[31:25],inst[11:7]}), and B (1100011) with imm=sext({inst[31],inst[7],inst[30:25],inst[11:8],0}); both: rd_e=0, rs1_e=rs2_e=1, imm_e=1; pc_e=0 for S, 1 for B.
REQ-011 SHALL decode U (0110111, 0010111) with imm=sext({inst[31:12],12'b0}), and J (1101111) with imm=sext({inst[31],inst[19:12],inst[20],inst[30:21],0}); both: rd_e=1, rs1_e=rs2_e=0, imm_e=1, pc_e=1, full_inst={10'b0,opcode}.
REQ-012 SHALL sign-extend every immediate from inst[31] to XLEN bits; every disabled register index SHALL be 5'b0.
REQ-013 SHALL decode any other opcode to all-zero fields (full_inst=0, all enables 0).
REQ-014 SHALL register decoded fields plus out_pc: one-cycle latency from in_valid&&in_ready to out_valid.
REQ-015 SHALL hold a main register and one skid register; state machine EMPTY, FULL (main valid), SKID (main and skid valid).
REQ-016 SHALL drive in_ready from registered state only: 1 in EMPTY and FULL, 0 in SKID; no combinational in_ready-from-out_ready path.
REQ-017 SHALL drive out_valid=1 in FULL and SKID; outputs SHALL come from the main register and be stable while out_valid&&!out_ready.
REQ-018 Transitions: EMPTY+push->FULL; FULL+push+pop->FULL (new entry in main); FULL+push-only->SKID (new entry in skid); FULL+pop-only->EMPTY; SKID+pop->FULL (skid moves to main); otherwise hold.
REQ-019 SHALL preserve instruction order; no drop or duplication under any out_ready pattern.
REQ-020 flush=1 SHALL force EMPTY at the next edge, override any simultaneous push or pop, and not accept the concurrent in_valid.

Reset
REQ-021 rst=1 SHALL asynchronously force EMPTY; out_valid=0, in_ready=1 and all decoded outputs, out_pc and illegal = 0.
REQ-022 Reset mid-handshake SHALL discard both entries; the first edge after rst deasserts SHALL behave as EMPTY.

Configuration
REQ-023 Macro DECODE_STAGE_ILLEGAL_EN: when defined, illegal=1 for an unlisted opcode, for R-type func7 other than 0000000/0100000, or for in_inst[1:0]!=2'b11; illegal is registered with the entry, and fields SHALL still follow REQ-008..REQ-013.
REQ-024 Without DECODE_STAGE_ILLEGAL_EN, illegal SHALL be tied to 0 and no detection logic SHALL be built.

Verification
REQ-025 Push 0xFFF00093 (addi x1,x0,-1), XLEN=32, out_ready=1 -> next cycle out_valid=1, rd=1, rs1=0, rs1_e=1, imm=0xFFFFFFFF, imm_e=1, full_inst=17'h00013.
REQ-026 Push 0x002081B3 then 0x402081B3 back-to-back -> rd=3, rs1=1, rs2=2, full_inst=17'h00033 then 17'h08033, one per cycle.
REQ-027 Push 0x008000EF (jal x1,8) with XLEN=64 -> imm=64'h8, pc_e=1, rd_e=1, rs1_e=0, full_inst=17'h0006F.
REQ-028 out_ready=0, push A,B,C on consecutive cycles -> C blocked by in_ready=0; release out_ready -> A,B,C emitted in order, C after re-push.
REQ-029 SKID state plus flush=1 with in_valid=1 -> next cycle out_valid=0, in_ready=1, no entries emitted.
REQ-030 With DECODE_STAGE_ILLEGAL_EN, push 0xFFFFFFFF -> illegal=1, all fields 0; without the macro -> illegal=0.
